// File: rtl/tile_paint_pipeline_if.sv
// Pixel, tile-write and colour bundle between the game/VGA side
// and the tile renderer.
interface tile_paint_pipeline_if #(
  parameter int GRID_W = 20,
  parameter int GRID_H = 15
);
  localparam int CXW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int CYW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  logic           video_on;
  logic [9:0]     x;
  logic [9:0]     y;
  logic           frame_start;
  logic           stage;
  logic           game_over;
  logic           wr_en;
  logic [CXW-1:0] wr_cx;
  logic [CYW-1:0] wr_cy;
  logic [1:0]     wr_code;
  logic           clr;
  logic           busy;
  logic [7:0]     R;
  logic [7:0]     G;
  logic [7:0]     B;

  modport master (
    output video_on, x, y, frame_start, stage, game_over,
    output wr_en, wr_cx, wr_cy, wr_code, clr,
    input  busy, R, G, B
  );

  modport slave (
    input  video_on, x, y, frame_start, stage, game_over,
    input  wr_en, wr_cx, wr_cy, wr_code, clr,
    output busy, R, G, B
  );
endinterface

// File: rtl/tile_paint_pipeline.sv
// Tile-map pixel renderer: 2-cycle lookup from (x,y) to RGB with
// grid lines, border, food blink, game-over flash and map clear.
module tile_paint_pipeline #(
  parameter int          CELL_SHIFT   = 5,
  parameter int          GRID_W       = 20,
  parameter int          GRID_H       = 15,
  parameter int          LINE_W       = 1,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [23:0] BG_RGB       = 24'h99A3A4,
  parameter logic [23:0] SNAKE_RGB    = 24'hF1C40F,
  parameter logic [23:0] HEAD_RGB     = 24'hD68910,
  parameter logic [23:0] FOOD_RGB     = 24'hFF2300,
  parameter logic [23:0] DEAD_RGB     = 24'hFFFFFF,
  parameter logic [23:0] LINE_RGB     = 24'h000000,
  parameter logic [23:0] BORDER_RGB   = 24'h2C3E50
) (
  input logic clk,
  input logic rst,
  tile_paint_pipeline_if.slave bus
);

  localparam int DEPTH = GRID_W * GRID_H;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int LHI   = (1 << CELL_SHIFT) - LINE_W;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [BW-1:0] BTOP = BW'(BLINK_FRAMES - 1);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] SNAKE = 2'd1;
  localparam logic [1:0] HEAD  = 2'd2;
  localparam logic [1:0] FOOD  = 2'd3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] idx;
  logic          busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      idx   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.clr) begin
            state <= ST_CLEAR;
            idx   <= '0;
          end
        end
        ST_CLEAR: begin
          if (idx == LAST)
            state <= ST_IDLE;
          else
            idx <= idx + 1'b1;
        end
      endcase
    end
  end

  assign busy     = (state == ST_CLEAR);
  assign bus.busy = busy;

  logic          wr_ok;
  logic [AW-1:0] wr_addr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [1:0]    wdata;

  assign wr_ok   = (32'(bus.wr_cx) < GRID_W) &&
                   (32'(bus.wr_cy) < GRID_H);
  assign wr_addr = AW'(bus.wr_cy) * AW'(GRID_W) + AW'(bus.wr_cx);

  // The clear owns the write port; user writes are dropped meanwhile.
  always_comb begin
    we    = 1'b0;
    waddr = idx;
    wdata = EMPTY;
    if (busy) begin
      we = 1'b1;
    end else if (bus.wr_en && wr_ok) begin
      we    = 1'b1;
      waddr = wr_addr;
      wdata = bus.wr_code;
    end
  end

  logic [9:0]            cx;
  logic [9:0]            cy;
  logic [CELL_SHIFT-1:0] ox;
  logic [CELL_SHIFT-1:0] oy;
  logic                  in_grid;
  logic                  line;
  logic [AW-1:0]         raddr;

  assign cx = bus.x >> CELL_SHIFT;
  assign cy = bus.y >> CELL_SHIFT;
  assign ox = bus.x[CELL_SHIFT-1:0];
  assign oy = bus.y[CELL_SHIFT-1:0];

  assign in_grid = (32'(cx) < GRID_W) && (32'(cy) < GRID_H);
  assign line    = (32'(ox) < LINE_W) || (32'(ox) >= LHI) ||
                   (32'(oy) < LINE_W) || (32'(oy) >= LHI);

  // Off-grid pixels read a fixed address so they never alias a cell.
  assign raddr = in_grid ? AW'(cy) * AW'(GRID_W) + AW'(cx) : '0;

  logic [1:0] mem [DEPTH];
  logic [1:0] rd_q;

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rd_q <= mem[raddr];
  end

  logic von1;
  logic stage1;
  logic grid1;
  logic line1;
  logic mask1;

  always_ff @(posedge clk) begin
    if (rst) begin
      von1   <= 1'b0;
      stage1 <= 1'b0;
      grid1  <= 1'b0;
      line1  <= 1'b0;
      mask1  <= 1'b0;
    end else begin
      von1   <= bus.video_on;
      stage1 <= bus.stage;
      grid1  <= in_grid;
      line1  <= line;
      mask1  <= busy;
    end
  end

  logic [BW-1:0] bcnt;
  logic          phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (bus.frame_start) begin
      if (bcnt == BTOP) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  logic [1:0]  code1;
  logic [23:0] rgb_d;
  logic [23:0] rgb_q;

  assign code1 = mask1 ? EMPTY : rd_q;

  always_comb begin
    rgb_d = BG_RGB;
    if (!von1)
      rgb_d = 24'h0;
    else if (!stage1)
      rgb_d = BG_RGB;
    else if (!grid1)
      rgb_d = BORDER_RGB;
    else if (code1 == SNAKE || code1 == HEAD)
      rgb_d = (bus.game_over && phase) ? DEAD_RGB :
              (code1 == HEAD) ? HEAD_RGB : SNAKE_RGB;
    else if (code1 == FOOD)
      rgb_d = phase ? BG_RGB : FOOD_RGB;
    else if (line1)
      rgb_d = LINE_RGB;
  end

  always_ff @(posedge clk) begin
    if (rst)
      rgb_q <= 24'h0;
    else
      rgb_q <= rgb_d;
  end

  assign bus.R = rgb_q[23:16];
  assign bus.G = rgb_q[15:8];
  assign bus.B = rgb_q[7:0];

endmodule

// File: tb/tb_tile_paint_pipeline.sv
// Bench for tile_paint_pipeline: vector table through a latency-2
// scoreboard plus hand sequences for clear, blink and reset.
module tb_tile_paint_pipeline;

  localparam logic [23:0] BG     = 24'h99A3A4;
  localparam logic [23:0] SNK    = 24'hF1C40F;
  localparam logic [23:0] HD     = 24'hD68910;
  localparam logic [23:0] FD     = 24'hFF2300;
  localparam logic [23:0] DEAD   = 24'hFFFFFF;
  localparam logic [23:0] LN     = 24'h000000;
  localparam logic [23:0] BORDER = 24'h2C3E50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tile_paint_pipeline_if #(.GRID_W(20), .GRID_H(15)) bus ();
  tile_paint_pipeline_if #(.GRID_W(19), .GRID_H(15)) bus2 ();

  tile_paint_pipeline dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  tile_paint_pipeline #(.GRID_W(19)) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  typedef struct {
    logic [23:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic        stg;
    logic [23:0] exp;
    string       name;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[14];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  logic chk = 1'b0;
  logic [1:0] vld = 2'b00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    vld <= {vld[0], chk};
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vld[1]) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check(e.name, {8'h0, bus.R, bus.G, bus.B}, {8'h0, e.exp});
      end
    end
  end

  task automatic pix(input logic [9:0] px, input logic [9:0] py,
                     input logic von, input logic stg,
                     input logic [23:0] exp, input string nm);
    sb_t e;
    @(negedge clk);
    bus.x        = px;
    bus.y        = py;
    bus.video_on = von;
    bus.stage    = stg;
    chk          = 1'b1;
    e.exp        = exp;
    e.name       = nm;
    sbq.push_back(e);
  endtask

  task automatic drain();
    @(negedge clk);
    chk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wr(input int cx, input int cy, input logic [1:0] code);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_cx   = 5'(cx);
    bus.wr_cy   = 4'(cy);
    bus.wr_code = code;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulses(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.frame_start = 1'b1;
      @(negedge clk);
      bus.frame_start = 1'b0;
    end
  endtask

  task automatic wait_low(input int t0, output int n);
    int k;
    k = 0;
    while (bus.busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (bus.busy)
      check("busy_timeout", 32'd1, 32'd0);
    n = cyc - t0;
  endtask

  initial begin
    int n;
    int t0;

    vecs[0]  = '{10'd40,   10'd40,   1'b1, 1'b1, BG,     "empty_bg"};
    vecs[1]  = '{10'd100,  10'd70,   1'b1, 1'b1, HD,     "head"};
    vecs[2]  = '{10'd96,   10'd70,   1'b1, 1'b1, HD,     "head_on_line"};
    vecs[3]  = '{10'd64,   10'd70,   1'b1, 1'b1, LN,     "line_left"};
    vecs[4]  = '{10'd70,   10'd64,   1'b1, 1'b1, LN,     "line_top"};
    vecs[5]  = '{10'd95,   10'd70,   1'b1, 1'b1, LN,     "line_right"};
    vecs[6]  = '{10'd10,   10'd10,   1'b1, 1'b1, FD,     "food_p0"};
    vecs[7]  = '{10'd170,  10'd170,  1'b1, 1'b1, SNK,    "snake"};
    vecs[8]  = '{10'd640,  10'd100,  1'b1, 1'b1, BORDER, "border_x"};
    vecs[9]  = '{10'd100,  10'd480,  1'b1, 1'b1, BORDER, "border_y"};
    vecs[10] = '{10'd100,  10'd70,   1'b0, 1'b1, 24'h0,  "video_off"};
    vecs[11] = '{10'd100,  10'd70,   1'b1, 1'b0, BG,     "title_head"};
    vecs[12] = '{10'd640,  10'd100,  1'b1, 1'b0, BG,     "title_border"};
    vecs[13] = '{10'd1023, 10'd1023, 1'b1, 1'b1, BORDER, "border_max"};

    bus.video_on = 1'b0;  bus.x = '0;  bus.y = '0;
    bus.frame_start = 1'b0;  bus.stage = 1'b0;  bus.game_over = 1'b0;
    bus.wr_en = 1'b0;  bus.wr_cx = '0;  bus.wr_cy = '0;
    bus.wr_code = 2'd0;  bus.clr = 1'b0;
    bus2.video_on = 1'b1;  bus2.x = 10'd639;  bus2.y = 10'd479;
    bus2.frame_start = 1'b0;  bus2.stage = 1'b1;  bus2.game_over = 1'b0;
    bus2.wr_en = 1'b0;  bus2.wr_cx = '0;  bus2.wr_cy = '0;
    bus2.wr_code = 2'd0;  bus2.clr = 1'b0;

    @(negedge clk);
    rst = 1'b0;
    check("rst_rgb", {8'h0, bus.R, bus.G, bus.B}, 32'h0);
    check("rst_busy", {31'h0, bus.busy}, 32'd1);
    t0 = cyc;
    wait_low(t0, n);
    check("init_clear_len", n, 32'd300);

    check("w19_border", {8'h0, bus2.R, bus2.G, bus2.B}, {8'h0, BORDER});
    bus2.x = 10'd600;
    repeat (3) @(negedge clk);
    check("w19_line", {8'h0, bus2.R, bus2.G, bus2.B}, {8'h0, LN});

    wr(3, 2, 2'd2);
    wr(0, 0, 2'd3);
    wr(5, 5, 2'd1);
    for (int i = 0; i < 14; i++)
      pix(vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].stg,
          vecs[i].exp, vecs[i].name);
    drain();

    pix(10'd140, 10'd140, 1'b1, 1'b1, BG, "raw_old");
    bus.wr_en = 1'b1;  bus.wr_cx = 5'd4;  bus.wr_cy = 4'd4;
    bus.wr_code = 2'd1;
    pix(10'd140, 10'd140, 1'b1, 1'b1, SNK, "raw_new");
    bus.wr_en = 1'b0;
    drain();

    pulses(29);
    pix(10'd10, 10'd10, 1'b1, 1'b1, FD, "blink_29");
    drain();
    pulses(1);
    pix(10'd10, 10'd10, 1'b1, 1'b1, BG, "blink_30");
    pix(10'd170, 10'd170, 1'b1, 1'b1, SNK, "snake_p1_alive");
    drain();
    bus.game_over = 1'b1;
    pix(10'd170, 10'd170, 1'b1, 1'b1, DEAD, "go_snake");
    pix(10'd100, 10'd70, 1'b1, 1'b1, DEAD, "go_head");
    pix(10'd10, 10'd10, 1'b1, 1'b1, BG, "go_food");
    pix(10'd40, 10'd40, 1'b1, 1'b1, BG, "go_empty");
    pix(10'd100, 10'd70, 1'b1, 1'b0, BG, "go_title");
    drain();
    pulses(30);
    pix(10'd10, 10'd10, 1'b1, 1'b1, FD, "blink_60");
    pix(10'd170, 10'd170, 1'b1, 1'b1, SNK, "go_phase0");
    drain();
    bus.game_over = 1'b0;

    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    t0 = cyc;
    check("clr_busy", {31'h0, bus.busy}, 32'd1);
    bus.wr_en = 1'b1;  bus.wr_cx = 5'd1;  bus.wr_cy = 4'd1;
    bus.wr_code = 2'd1;
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.clr = 1'b0;
    pix(10'd170, 10'd170, 1'b1, 1'b1, BG, "busy_mask");
    drain();
    wait_low(t0, n);
    check("clr_len", n, 32'd300);
    pix(10'd40, 10'd40, 1'b1, 1'b1, BG, "clr_wr_ignored");
    pix(10'd170, 10'd170, 1'b1, 1'b1, BG, "clr_snake_gone");
    pix(10'd100, 10'd70, 1'b1, 1'b1, BG, "clr_head_gone");
    pix(10'd10, 10'd10, 1'b1, 1'b1, BG, "clr_food_gone");
    drain();
    wr(1, 1, 2'd1);
    pix(10'd40, 10'd40, 1'b1, 1'b1, SNK, "wr_after_clr");
    drain();

    pulses(40);
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    repeat (150) @(negedge clk);
    check("mid_busy", {31'h0, bus.busy}, 32'd1);
    rst = 1'b1;
    bus.frame_start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.frame_start = 1'b0;
    t0 = cyc;
    check("mid_rst_rgb", {8'h0, bus.R, bus.G, bus.B}, 32'h0);
    wait_low(t0, n);
    check("mid_rst_len", n, 32'd300);
    wr(0, 0, 2'd3);
    pix(10'd10, 10'd10, 1'b1, 1'b1, FD, "phase_rst");
    drain();
    pulses(29);
    pix(10'd10, 10'd10, 1'b1, 1'b1, FD, "cnt_rst");
    drain();

    if (sbq.size() != 0)
      check("sb_leftover", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
